// File: rtl/temporal_ngram_encoder_pkg.sv
// Shared types and helpers for the temporal n-gram encoder.
// HV_DIMENSION normally comes from the project const.vh; a local default keeps the slice standalone.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

package temporal_ngram_encoder_pkg;

  localparam int unsigned HvDim    = `HV_DIMENSION;
  localparam int unsigned MinNgram = 2;
  localparam int unsigned MaxNgram = 8;

  typedef logic [HvDim-1:0] hv_t;

  typedef enum logic [0:0] {
    StFill,
    StStream
  } tenc_state_e;

  // Rotate left: result bit i takes x[(i-k) mod HvDim]; wiring only.
  function automatic hv_t hv_rotl(hv_t x, int k);
    int unsigned s;
    s = unsigned'(k) % HvDim;
    if (s == 0) begin
      return x;
    end
    return (x << s) | (x >> (HvDim - s));
  endfunction

endpackage

// File: rtl/temporal_ngram_encoder_if.sv
// Valid/ready bundle between spatial encoder, n-gram encoder and associative memory.
// The flush wire exists only when TEMPORAL_FLUSH_EN is defined.
interface temporal_ngram_encoder_if;
  import temporal_ngram_encoder_pkg::*;

  logic hvin_valid;
  logic hvin_ready;
  hv_t  hvin;
  logic dout_valid;
  logic dout_ready;
  hv_t  hvout;
`ifdef TEMPORAL_FLUSH_EN
  logic flush;

  modport master (
    output hvin_valid, hvin, dout_ready, flush,
    input  hvin_ready, dout_valid, hvout
  );

  modport slave (
    input  hvin_valid, hvin, dout_ready, flush,
    output hvin_ready, dout_valid, hvout
  );
`else
  modport master (
    output hvin_valid, hvin, dout_ready,
    input  hvin_ready, dout_valid, hvout
  );

  modport slave (
    input  hvin_valid, hvin, dout_ready,
    output hvin_ready, dout_valid, hvout
  );
`endif

endinterface

// File: rtl/temporal_ngram_encoder_bind.sv
// hv_ngram_bind: combinational n-gram binding, XOR of each history entry rotated by its age.
module hv_ngram_bind
  import temporal_ngram_encoder_pkg::*;
#(
  parameter int unsigned NGRAM_SIZE = 3
) (
  input  hv_t hist [NGRAM_SIZE],
  output hv_t hv
);

  always_comb begin
    hv = '0;
    for (int k = 0; k < NGRAM_SIZE; k++) begin
      hv ^= hv_rotl(hist[k], k);
    end
  end

endmodule

// File: rtl/temporal_ngram_encoder.sv
// Temporal n-gram encoder: binds the last NGRAM_SIZE spatial HVs into one registered n-gram HV.
// Optional TEMPORAL_FLUSH_EN adds a synchronous history flush.
module temporal_ngram_encoder
  import temporal_ngram_encoder_pkg::*;
#(
  parameter int unsigned NGRAM_SIZE = 3,
  parameter int unsigned HV_DIM     = `HV_DIMENSION
) (
  input logic                     clk,
  input logic                     rst,
  temporal_ngram_encoder_if.slave bus
);

  localparam int unsigned CntW = $clog2(NGRAM_SIZE + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t FillLast = cnt_t'(NGRAM_SIZE - 1);
  localparam cnt_t FillFull = cnt_t'(NGRAM_SIZE);

  if (NGRAM_SIZE < MinNgram || NGRAM_SIZE > MaxNgram) begin : g_bad_ngram
    $error("NGRAM_SIZE out of range 2..8");
  end
  if (HV_DIM != HvDim) begin : g_bad_dim
    $error("HV_DIM must equal HV_DIMENSION");
  end

  hv_t         hist_q     [NGRAM_SIZE];
  hv_t         hist_d     [NGRAM_SIZE];
  hv_t         hist_shift [NGRAM_SIZE];
  hv_t         bound;
  hv_t         hvout_q, hvout_d;
  cnt_t        fill_q, fill_d;
  tenc_state_e state_q, state_d;
  logic        dout_valid_q, dout_valid_d;
  logic        flush_req;
  logic        hvin_ready;
  logic        hvin_fire;
  logic        dout_fire;
  logic        emit;

`ifdef TEMPORAL_FLUSH_EN
  assign flush_req = bus.flush;
`else
  assign flush_req = 1'b0;
`endif

  // Ready depends only on registered state and downstream ready, never on hvin_valid.
  assign hvin_ready = (!dout_valid_q || bus.dout_ready) && !flush_req;
  assign hvin_fire  = bus.hvin_valid && hvin_ready;
  assign dout_fire  = dout_valid_q && bus.dout_ready;

  always_comb begin
    hist_shift[0] = bus.hvin;
    for (int k = 1; k < NGRAM_SIZE; k++) begin
      hist_shift[k] = hist_q[k-1];
    end
  end

  hv_ngram_bind #(
    .NGRAM_SIZE(NGRAM_SIZE)
  ) u_bind (
    .hist(hist_shift),
    .hv  (bound)
  );

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    hist_d       = hist_q;
    dout_valid_d = dout_valid_q;
    hvout_d      = hvout_q;
    emit         = 1'b0;

    if (dout_fire) begin
      dout_valid_d = 1'b0;
    end

    // A pending output survives a flush; only the history restarts.
    if (flush_req) begin
      state_d = StFill;
      fill_d  = '0;
      for (int k = 0; k < NGRAM_SIZE; k++) begin
        hist_d[k] = '0;
      end
    end else if (hvin_fire) begin
      hist_d = hist_shift;
      if (fill_q != FillFull) begin
        fill_d = fill_q + 1'b1;
      end
      unique case (state_q)
        StFill: begin
          if (fill_q == FillLast) begin
            emit    = 1'b1;
            state_d = StStream;
          end
        end
        StStream: emit = 1'b1;
        default: ;
      endcase
    end

    if (emit) begin
      dout_valid_d = 1'b1;
      hvout_d      = bound;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StFill;
      fill_q       <= '0;
      dout_valid_q <= 1'b0;
      hvout_q      <= '0;
      for (int k = 0; k < NGRAM_SIZE; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      dout_valid_q <= dout_valid_d;
      hvout_q      <= hvout_d;
      hist_q       <= hist_d;
    end
  end

  assign bus.hvin_ready = hvin_ready;
  assign bus.dout_valid = dout_valid_q;
  assign bus.hvout      = hvout_q;

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Randomized bench for temporal_ngram_encoder against a window/queue reference model.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module tb_temporal_ngram_encoder;
  import temporal_ngram_encoder_pkg::*;

  localparam int N = 3;
  localparam int D = `HV_DIMENSION;
  typedef logic [D-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  temporal_ngram_encoder_if bus ();

  temporal_ngram_encoder #(
    .NGRAM_SIZE(N),
    .HV_DIM    (D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: last N accepted inputs (win[0] newest), and outputs still owed downstream.
  vec_t win [N];
  int   fed;
  vec_t exp_q [$];
  vec_t held;
  bit   stalled_prev;

  function automatic vec_t onehot(int i);
    vec_t v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic vec_t rand_hv();
    vec_t v;
    for (int i = 0; i < D; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Bit i of the n-gram is the parity of win[k] bit (i-k) mod D over all k.
  function automatic vec_t ngram_ref();
    vec_t r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      for (int k = 0; k < N; k++) r[i] = r[i] ^ win[k][(i - k + D) % D];
    end
    return r;
  endfunction

  task automatic check(string tag, vec_t got, vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ones=%0d low=%h, expected ones=%0d low=%h", tag,
               $countones(got), got[63:0], $countones(exp), exp[63:0]);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) win[k] = '0;
    fed = 0;
    exp_q.delete();
    stalled_prev = 1'b0;
  endtask

  task automatic model_flush();
    for (int k = 0; k < N; k++) win[k] = '0;
    fed = 0;
  endtask

  // One clock: drive at negedge, sample 1ns later, predict what the next posedge does.
  task automatic step(bit v, vec_t d, bit r, bit f);
    bit exp_ready;
    @(negedge clk);
    bus.hvin_valid = v;
    bus.hvin       = d;
    bus.dout_ready = r;
`ifdef TEMPORAL_FLUSH_EN
    bus.flush      = f;
`endif
    #1;
    check("dout_valid", vec_t'(bus.dout_valid), vec_t'(exp_q.size() != 0));
    if (stalled_prev) check("hvout_hold", bus.hvout, held);
    exp_ready = (!bus.dout_valid || r) && !f;
    check("hvin_ready", vec_t'(bus.hvin_ready), vec_t'(exp_ready));
    if (bus.dout_valid && r && exp_q.size() != 0) check("hvout", bus.hvout, exp_q.pop_front());
    stalled_prev = bus.dout_valid && !r;
    held         = bus.hvout;
    if (f) begin
      model_flush();
    end else if (v && exp_ready) begin
      for (int k = N - 1; k > 0; k--) win[k] = win[k-1];
      win[0] = d;
      fed++;
      if (fed >= N) exp_q.push_back(ngram_ref());
    end
  endtask

  task automatic peek(string tag, vec_t exp);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, vec_t'(bus.dout_valid), vec_t'(1));
    check(tag, bus.hvout, exp);
  endtask

  initial begin
    bus.hvin_valid = 1'b0;
    bus.hvin       = '0;
    bus.dout_ready = 1'b0;
`ifdef TEMPORAL_FLUSH_EN
    bus.flush      = 1'b0;
`endif
    model_clear();
    rst = 1'b0;
    #12;
    check("rst_dout_valid", vec_t'(bus.dout_valid), vec_t'(0));
    check("rst_hvout", bus.hvout, '0);
    check("rst_hvin_ready", vec_t'(bus.hvin_ready), vec_t'(1));
    @(negedge clk);
    rst = 1'b1;

    // Warm-up then first output e2.
    step(1, onehot(0), 1, 0);
    step(1, '0, 1, 0);
    step(1, '0, 1, 0);
    peek("t1_e2", onehot(2));

    // Full-rate streaming.
    step(1, onehot(5), 1, 0);
    step(1, onehot(7), 1, 0);
    peek("t2_e7e6", onehot(7) | onehot(6));

    // Backpressure with input held valid.
    step(1, onehot(9), 1, 0);
    for (int i = 0; i < 5; i++) step(1, onehot(100 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(1, rand_hv(), 1, 0);
    step(0, '0, 1, 0);

    // Rotation wraps around the top bit.
    step(1, onehot(D - 1), 1, 0);
    step(1, '0, 1, 0);
    step(1, '0, 1, 0);
    peek("t4_wrap", onehot(1));

    // Asynchronous reset between edges discards the pending output.
    step(1, rand_hv(), 1, 0);
    step(1, rand_hv(), 1, 0);
    @(posedge clk);
    #3;
    bus.hvin_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_dout_valid", vec_t'(bus.dout_valid), vec_t'(0));
    check("arst_hvout", bus.hvout, '0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    step(1, rand_hv(), 1, 0);
    step(1, rand_hv(), 1, 0);
    step(1, rand_hv(), 1, 0);
    step(0, '0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit   v, r, f;
      vec_t d;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      d = ($urandom_range(0, 1) != 0) ? rand_hv() : onehot(int'($urandom_range(0, D - 1)));
      f = 1'b0;
`ifdef TEMPORAL_FLUSH_EN
      f = ($urandom_range(0, 29) == 0);
`endif
      step(v, d, r, f);
    end

    for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    check("drain_empty", vec_t'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
